// File: rtl/alu_misr_16.sv
// 16-bit ALU output response analyzer: compacts NUM_SAMPLES words into a MISR and compares against a golden value.
// Optional feature macro: ALU_MISR_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
module alu_misr_16 #(
  parameter int              WIDTH       = 16,
  parameter int              NUM_SAMPLES = 20,
  parameter logic [WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [WIDTH-1:0] SEED       = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] expected,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      count
`ifdef ALU_MISR_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);

  // One Galois shift-left MISR step with the data word folded in.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] fb;
    fb = sig[WIDTH-1] ? POLY : {WIDTH{1'b0}};
    return {sig[WIDTH-2:0], 1'b0} ^ fb ^ data;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] signature_q, signature_d;
  logic [15:0]      count_q, count_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // Next-state, signature and count computation.
  always_comb begin
    state_d     = state_q;
    signature_d = signature_q;
    count_d     = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          signature_d = SEED;
          count_d     = 16'd0;
          state_d     = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        // A restart wins over a coincident word, which is dropped.
        if (start) begin
          signature_d = SEED;
          count_d     = 16'd0;
          state_d     = ST_CAPTURE;
        end else if (in_valid) begin
          signature_d = misr_step(signature_q, in_data);
          count_d     = count_q + 16'd1;
          if (count_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (start) begin
          signature_d = SEED;
          count_d     = 16'd0;
          state_d     = ST_CAPTURE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        signature_d = SEED;
        count_d     = 16'd0;
      end
    endcase
    ready_d = (state_d == ST_CAPTURE);
    done_d  = (state_d == ST_DONE);
  end

  // State, signature, count and decoded status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      signature_q <= SEED;
      count_q     <= 16'd0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      signature_q <= signature_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

`ifdef ALU_MISR_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of words offered while not accepting.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (start) begin
      drop_cnt_d = 8'd0;
    end else if (in_valid && !ready_q && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign in_ready  = ready_q;
  assign busy      = ready_q;
  assign done      = done_q;
  assign pass      = done_q && (signature_q == expected);
  assign signature = signature_q;
  assign count     = count_q;

endmodule
